// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ro_in over a fixed gate window.
// Define RO_FREQ_CONT_EN to restart measurements automatically after each valid/ready handshake.
module ro_freq_counter #(
    parameter int unsigned GATE_CYCLES   = 133000,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned CNT_W         = 24
) (
    input  logic             fpga_clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic             ro_in,
    output logic             ro_en,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             valid,
    input  logic             ready
);

    localparam int unsigned T_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned TW    = $clog2(T_MAX + 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] GATE_LD   = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, HOLD} state_t;

    state_t           state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ro_en_q, ro_en_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             sync1_q, sync2_q, hist_q;
    logic             edge_pulse;

    assign edge_pulse = sync2_q & ~hist_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        ro_en_d = ro_en_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SETTLE;
                    timer_d = SETTLE_LD;
                    ro_en_d = 1'b1;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            SETTLE: begin
                if (timer_q == '0) begin
                    state_d = GATE;
                    timer_d = GATE_LD;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GATE: begin
                // Saturate at all-ones; any further edge flags overflow instead.
                if (edge_pulse) begin
                    if (&count_q) ovf_d = 1'b1;
                    else          count_d = count_q + 1'b1;
                end
                if (timer_q == '0) begin
                    state_d = HOLD;
                    timer_d = '0;
                    ro_en_d = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            HOLD: begin
                if (valid_q && ready) begin
                    valid_d = 1'b0;
`ifdef RO_FREQ_CONT_EN
                    state_d = SETTLE;
                    timer_d = SETTLE_LD;
                    ro_en_d = 1'b1;
                    count_d = '0;
                    ovf_d   = 1'b0;
`else
                    state_d = IDLE;
                    timer_d = '0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            ro_en_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            hist_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            ro_en_q <= ro_en_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            sync1_q <= ro_in;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign ro_en    = ro_en_q;
    assign busy     = (state_q == SETTLE) || (state_q == GATE);
    assign count    = count_q;
    assign overflow = ovf_q;
    assign valid    = valid_q;

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 Parameter GATE_CYCLES, default 133000: length of the measurement window in fpga_clock cycles (1 ms at 133 MHz); legal range ≥ 1.
REQ-002 Parameter SETTLE_CYCLES, default 16: cycles the ring runs before counting starts; legal range ≥ 1.
REQ-003 Parameter CNT_W, default 24: width of the edge count.
REQ-004 The block SHALL use one clock, fpga_clock; reset is rst_n, asynchronous and active-low.
REQ-005 Port fpga_clock, input, 1: system clock.
REQ-006 Port rst_n, input, 1: asynchronous active-low reset.
REQ-007 Port start, input, 1: measurement request, sampled in IDLE only.
REQ-008 Port ro_in, input, 1: ring oscillator output, asynchronous to fpga_clock.
REQ-009 Port ro_en, output, 1: enable to the ring oscillator en input, registered.
REQ-010 Port busy, output, 1: high in SETTLE and GATE.
REQ-011 Port count, output, CNT_W: rising-edge count of ro_in over the gate window.
REQ-012 Port overflow, output, 1: count saturated during the last window.
REQ-013 Port valid, output, 1: count/overflow hold a result.
REQ-014 Port ready, input, 1: consumer accepts the result.

Function
REQ-015 ro_in SHALL pass through a 2-flop synchronizer, then a third history flop; an edge pulse is sync2 & ~hist.
REQ-016 FSM states: IDLE, SETTLE, GATE, HOLD.
REQ-017 IDLE -> SETTLE when start=1; on that edge, ro_en<=1, count<=0, overflow<=0, and the timer loads.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles; no edges are counted, then it moves to GATE.
REQ-019 GATE SHALL last exactly GATE_CYCLES cycles; each edge pulse in a GATE cycle increments count by 1.
REQ-020 At all-ones, count SHALL saturate and hold; an edge pulse while saturated sets overflow=1.
REQ-021 On GATE -> HOLD, ro_en<=0 and valid<=1 on the first HOLD cycle; count and overflow stay stable while valid=1.
REQ-022 HOLD -> IDLE on a cycle with valid & ready; valid<=0 on the next edge.
REQ-023 start SHALL be ignored outside IDLE, including the HOLD cycle in which ready completes the handshake.
REQ-024 A single shared timer, width clog2(max(GATE_CYCLES, SETTLE_CYCLES)+1), counts down and reloads on each state entry.
REQ-025 Resolution: input frequencies below fpga_clock/2 are counted to ±1 edge; higher frequencies alias, which is not an error.

Reset
REQ-026 When rst_n=0, the block SHALL immediately force state=IDLE, ro_en=0, busy=0, valid=0, count=0, overflow=0, timer=0, and all synchronizer flops to 0.
REQ-027 Reset asserted during SETTLE or GATE SHALL drop ro_en without waiting for a clock edge, and the partial result is discarded.
REQ-028 After rst_n deasserts, the block SHALL remain in IDLE until start=1.

Configuration
REQ-029 Macro RO_FREQ_CONT_EN: when defined, the block SHALL enter SETTLE directly after a valid & ready handshake in HOLD (continuous measurement), with start needed only for the first run; continuous mode ends only on reset.
REQ-030 When RO_FREQ_CONT_EN is undefined, the block SHALL return to IDLE after each handshake, per REQ-022.

Verification (GATE_CYCLES=100, SETTLE_CYCLES=4, CNT_W=8 unless stated)
REQ-031 Basic measurement: ro_in square wave with a period of 10 fpga_clock cycles, start pulsed once -> ro_en high for 104 cycles, valid=1, count=10±1, overflow=0.
REQ-032 Backpressure: ready held 0 for 50 cycles after valid -> valid and count stay stable; ready=1 -> valid=0 next cycle, state IDLE, ro_en=0.
REQ-033 Saturation: CNT_W=4, ro_in period of 4 cycles -> count=15, overflow=1.
REQ-034 Reset mid-GATE: rst_n=0 at cycle 50 of GATE -> ro_en=0 asynchronously, count=0, valid=0; a later start gives a fresh correct result.
REQ-035 Ignored start: start held high through the whole run and through the ready cycle -> exactly one measurement (without RO_FREQ_CONT_EN); ro_in constant 0 -> count=0.
REQ-036 Continuous mode (RO_FREQ_CONT_EN defined): ready tied 1 -> a new valid every 105 cycles, ro_en low for exactly one cycle between runs.
